// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit; the divider is built only when MDU_DIV_EN is defined.
// Latency: done is high 34 cycles after the accepting edge (a divide request without MDU_DIV_EN finishes after 1 cycle).
// Backpressure: stall holds the PC stage while busy and in the accepting cycle; start/mthi/mtlo are ignored while busy.
module mult_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    input  logic            mthi,
    input  logic            mtlo,
    output logic            busy,
    output logic            done,
    output logic            stall,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
`ifdef MDU_DIV_EN
    localparam logic [2:0] S_DIV  = 3'd2;
`endif
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]        state;
    logic [4:0]        cnt;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc;
    logic              neg_res;

    logic              idle_or_done;
    logic              accept;
    logic              signed_op;
    logic              rs_neg;
    logic              rt_neg;
    logic [XLEN-1:0]   rs_abs;
    logic [XLEN-1:0]   rt_abs;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   fix_hi;
    logic [XLEN-1:0]   fix_lo;

    assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
    assign accept       = start && idle_or_done;
    assign busy         = !idle_or_done;
    assign done         = (state == S_DONE);
    assign stall        = busy || accept;

    // Magnitudes feed both datapaths; signs are reapplied in FIX.
    assign signed_op = !op[0];
    assign rs_neg    = signed_op && rs_data[XLEN-1];
    assign rt_neg    = signed_op && rt_data[XLEN-1];
    assign rs_abs    = rs_neg ? -rs_data : rs_data;
    assign rt_abs    = rt_neg ? -rt_data : rt_data;

    // acc = {partial product, remaining multiplier bits}; opnd holds the multiplicand.
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    assign mul_next = {mul_sum, acc[XLEN-1:1]};
    assign prod     = neg_res ? -acc : acc;

`ifdef MDU_DIV_EN
    logic              is_div;
    logic              neg_rem;
    logic              div_zero;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_sub;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;

    // acc = {remainder, dividend bits still to shift in / quotient bits}; opnd holds the divisor.
    assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_sub   = div_shift[XLEN-1:0] - opnd;
    assign div_next  = div_ge ? {div_sub, acc[XLEN-2:0], 1'b1}
                              : {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    assign quo       = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem       = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    // A zero divisor leaves the dividend in the remainder; only the quotient needs forcing.
    assign fix_hi    = is_div ? rem : prod[2*XLEN-1:XLEN];
    assign fix_lo    = is_div ? (div_zero ? {XLEN{1'b1}} : quo) : prod[XLEN-1:0];
`else
    assign fix_hi    = prod[2*XLEN-1:XLEN];
    assign fix_lo    = prod[XLEN-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 5'd0;
            opnd    <= '0;
            acc     <= '0;
            neg_res <= 1'b0;
            hi      <= '0;
            lo      <= '0;
`ifdef MDU_DIV_EN
            is_div   <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        cnt     <= 5'd0;
                        opnd    <= op[1] ? rt_abs : rs_abs;
                        acc     <= {{XLEN{1'b0}}, (op[1] ? rs_abs : rt_abs)};
                        neg_res <= rs_neg ^ rt_neg;
`ifdef MDU_DIV_EN
                        is_div   <= op[1];
                        neg_rem  <= rs_neg;
                        div_zero <= (rt_data == '0);
                        state    <= op[1] ? S_DIV : S_MUL;
`else
                        state    <= op[1] ? S_DONE : S_MUL;
`endif
                    end else begin
                        if (mthi) hi <= rs_data;
                        if (mtlo) lo <= rs_data;
                        state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= S_FIX;
                end
`ifdef MDU_DIV_EN
                S_DIV: begin
                    acc <= div_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= S_FIX;
                end
`endif
                S_FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: arithmetic reference model, queued expectations, decoupled done monitor.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    mult_div_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
        .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    int          busy_from = 1;
    int          busy_to = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp_v);
        end
    endtask

    // Plain-arithmetic reference: {hi, lo} after an accepted request.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] cur_hi, input logic [31:0] cur_lo);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            2'd0: return 64'(sa * sb);
            2'd1: return ua * ub;
`ifdef MDU_DIV_EN
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            2'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
`endif
            default: return {cur_hi, cur_lo};
        endcase
    endfunction

    // Monitor: checks busy/stall every cycle and pops the scoreboard on done.
    initial begin
        exp_t e;
        bit   busy_exp;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                busy_exp = (cyc >= busy_from) && (cyc <= busy_to);
                chk("busy", busy, busy_exp);
                chk("stall", stall, busy_exp || (start && !busy_exp));
                if (done) begin
                    if (sb_q.size() == 0) begin
                        chk("done_unexpected", done, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("done_cycle", cyc, e.cyc);
                        chk("result_hi", hi, e.hi);
                        chk("result_lo", lo, e.lo);
                    end
                end else if (sb_q.size() > 0 && cyc > sb_q[0].cyc) begin
                    chk("done_missing", done, 1);
                    e = sb_q.pop_front();
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", busy, 0);
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic with_mtlo);
        logic [63:0] r;
        exp_t        e;
        int          e0;
        int          lat;
        r  = ref_model(o, a, b, m_hi, m_lo);
        e0 = cyc + 1;
`ifdef MDU_DIV_EN
        lat = 34;
`else
        lat = o[1] ? 1 : 34;
`endif
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        mtlo    = with_mtlo;
        e.hi  = r[63:32];
        e.lo  = r[31:0];
        e.cyc = e0 + lat - 1;
        sb_q.push_back(e);
        if (lat == 34) begin
            busy_from = e0;
            busy_to   = e0 + 32;
        end
        m_hi = r[63:32];
        m_lo = r[31:0];
        @(negedge clk);
        start = 1'b0;
        mtlo  = 1'b0;
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        wait_idle();
        issue(o, a, b, 1'b0);
    endtask

    task automatic chk_hilo(input string name);
        chk({name, "_hi"}, hi, m_hi);
        chk({name, "_lo"}, lo, m_lo);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          n;
        start = 0; op = 0; rs_data = 0; rt_data = 0; mthi = 0; mtlo = 0; rst = 1;
        repeat (3) @(negedge clk);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_stall", stall, 0);
        rst = 0;
        mon_en = 1'b1;
        @(negedge clk);

        // Directed corner cases.
        run(2'd0, 32'hFFFF_FFFF, 32'h0000_0002);
        run(2'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        run(2'd2, 32'hFFFF_FFF9, 32'h0000_0002);
        run(2'd3, 32'd100, 32'd7);
        run(2'd3, 32'd5, 32'd0);
        run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run(2'd2, 32'hFFFF_FFF0, 32'd0);
        run(2'd2, 32'd9, 32'd3);
        wait_idle();
        chk_hilo("after_directed");

        // Reset in the middle of a multiply: no done, registers cleared.
        @(negedge clk);
        issue(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        busy_to = cyc;
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_done", done, 0);
        chk_hilo("abort");
        rs_data = 32'h0000_1234;
        mthi = 1'b1;
        @(negedge clk);
        mthi = 1'b0;
        m_hi = 32'h0000_1234;
        chk_hilo("mthi");

        // start/mthi/mtlo while busy are ignored; operands are not re-sampled.
        issue(2'd1, 32'hDEAD_BEEF, 32'h0000_0003, 1'b0);
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1; op = 2'd3;
        rs_data = 32'h0000_AAAA; rt_data = 32'd0;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        wait_idle();
        chk_hilo("busy_ignore");

        // mtlo coinciding with an accepted start loses to start.
        @(negedge clk);
        issue(2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1);
        wait_idle();
        chk_hilo("mtlo_vs_start");

        // Both move-to writes in one cycle.
        @(negedge clk);
        rs_data = 32'h5555_0000;
        mthi = 1'b1;
        mtlo = 1'b1;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        m_hi = 32'h5555_0000;
        m_lo = 32'h5555_0000;
        chk_hilo("mthi_mtlo");

        // Back-to-back random traffic: each start is issued in the DONE cycle of the previous op.
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: a = {$urandom_range(0, 1) == 0 ? 1'b0 : 1'b1, 31'(b)};
                default: ;
            endcase
            run(2'($urandom_range(0, 3)), a, b);
        end

        n = 0;
        while (sb_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb_q.size(), 0);
        wait_idle();
        chk_hilo("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand width; only 32 is supported.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  in  1  request a multiply or divide, sampled each rising edge.
REQ-005 SHALL have port op  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
REQ-006 SHALL have port rs_data  in  32  multiplicand or dividend, plus mthi/mtlo write data.
REQ-007 SHALL have port rt_data  in  32  multiplier or divisor.
REQ-008 SHALL have ports mthi and mtlo  in  1 each  write rs_data to HI or LO.
REQ-009 SHALL have port busy  out  1  operation in progress.
REQ-010 SHALL have port done  out  1  one-cycle completion pulse.
REQ-011 SHALL have port stall  out  1  combinational hold request to the PC stage.
REQ-012 SHALL have ports hi and lo  out  32 each  registered HI and LO result.

Function
REQ-013 SHALL implement states IDLE, MUL, DIV, FIX and DONE.
REQ-014 SHALL accept start only in IDLE or DONE.
- On acceptance: latch operands; take absolute values for mult/div; record result signs; clear the 5-bit iteration counter.
- Next state: MUL for op 0x, DIV for op 1x.
REQ-015 MUL SHALL perform one shift-add step per cycle for exactly 32 cycles on a 64-bit accumulator, then go to FIX.
REQ-016 DIV SHALL perform one restoring shift-subtract step per cycle for exactly 32 cycles, then go to FIX.
REQ-017 FIX SHALL apply sign correction, then write hi/lo and enter DONE.
- mult: negate the 64-bit product when the operand signs differ.
- div: negate the quotient when signs differ; remainder takes the dividend's sign.
REQ-018 DONE SHALL assert done for exactly one cycle, then go to IDLE, or to MUL/DIV if start is accepted.
REQ-019 Latency SHALL be fixed: done is high in the 34th cycle after the accepting edge; busy is high during MUL, DIV and FIX only.
REQ-020 stall SHALL equal busy OR (start AND state is IDLE or DONE).
REQ-021 Divide by zero SHALL take the normal latency and yield lo=0xFFFFFFFF, hi=dividend.
REQ-022 div 0x80000000 by 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0.
REQ-023 mthi/mtlo SHALL write on the next edge only when the block is not busy and start is not accepted.
- If start is accepted in the same cycle, start wins and the write is dropped.
- If mthi and mtlo are both high, both registers are written.
REQ-024 start, mthi and mtlo SHALL be ignored while busy.
- Operands are not re-sampled mid-operation.
REQ-025 hi/lo SHALL hold their values except on FIX completion, mthi/mtlo writes, or reset.

Reset
REQ-026 rst SHALL force on the next edge: state IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
REQ-027 rst asserted mid-operation SHALL abort the operation with no hi/lo update and no done pulse.
REQ-028 rst SHALL take priority over start, mthi and mtlo.

Configuration
REQ-029 Macro MDU_DIV_EN defined: divide datapath and DIV state SHALL be compiled in and behave as specified above.
REQ-030 MDU_DIV_EN undefined: divide logic SHALL be compiled out.
- op 1x with start: done pulses on the next cycle; busy never rises; hi/lo are unchanged.
- stall is high only in the accepting cycle.

Verification
REQ-031 mult 0xFFFFFFFF x 0x00000002 -> done at cycle 34: hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu of the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-032 div 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 100/7 -> lo=14, hi=2.
REQ-033 divu 5/0 -> lo=0xFFFFFFFF, hi=5 after 34 cycles; div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 Pulse rst at cycle 10 of a mult -> next cycle idle, hi=lo=0, no done pulse; a following mthi 0x1234 -> hi=0x1234.
REQ-035 mtlo 0xAAAA with start during busy -> both ignored; mtlo together with start while idle -> lo takes the product, not 0xAAAA; back-to-back start held in DONE -> second done exactly 34 cycles after the first.
REQ-036 Build without MDU_DIV_EN and issue div 9/3 -> done on the next cycle, busy=0, hi/lo unchanged.
